fip_32_cramer_solver: RTL and testbench

//  Solves the 3x3 Q16.16 linear system A*x = b by Cramer's rule (ray/triangle barycentric solve).

---
 rtl/fip_32_cramer_solver.sv | 243 ++++++++++++++++++++++++
 tb/tb_fip_32_cramer_solver.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fip_32_cramer_solver.sv
// 3x3 Q16.16 linear solver (Cramer's rule). One determinant unit and one divider
// are shared across a fixed schedule: det(A), det(A_0..2), then three divides.

module fip_32_3b3_det (
  input  logic [0:2][0:2][31:0] i_m,
  output logic [31:0]           o_det,
  output logic                  o_ovf
);
  logic signed [98:0] term [3];
  logic signed [98:0] sum;
  logic signed [66:0] det_full;

  // Row-0 expansion; cyclic column order gives each cofactor its sign for free.
  for (genvar gi = 0; gi < 3; gi++) begin : g_cof
    localparam int C1 = (gi + 1) % 3;
    localparam int C2 = (gi + 2) % 3;
    logic signed [64:0] cof;
    assign cof = 65'($signed(i_m[1][C1])) * 65'($signed(i_m[2][C2]))
               - 65'($signed(i_m[1][C2])) * 65'($signed(i_m[2][C1]));
    assign term[gi] = 99'($signed(i_m[0][gi])) * 99'(cof);
  end

  assign sum      = term[0] + term[1] + term[2];
  assign det_full = 67'(sum >>> 32);
  assign o_det    = det_full[31:0];
  assign o_ovf    = det_full[66:31] != {36{det_full[31]}};
endmodule

module fip_32_div (
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic [31:0] o_quot,
  output logic        o_ovf,
  output logic        o_unf
);
  logic signed [63:0] num;
  logic signed [63:0] den;
  logic signed [63:0] quot;

  assign num = 64'($signed({i_dividend, 16'h0000}));
  assign den = 64'($signed(i_divisor));

  always_comb begin
    quot  = '0;
    o_ovf = 1'b0;
    o_unf = 1'b0;
    if (den == 64'sd0) begin
      o_ovf = 1'b1;
    end else begin
      quot  = num / den;
      o_ovf = quot[63:31] != {33{quot[31]}};
      o_unf = (num != 64'sd0) && (quot == 64'sd0);
    end
    o_quot = quot[31:0];
  end
endmodule

module fip_32_cramer_solver #(
  parameter logic [31:0] SINGULAR_EPS = 32'd0,
  parameter logic        OVF_ABORT    = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [0:2][0:2][31:0] i_matrix,
  input  logic [0:2][31:0]      i_rhs,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [0:2][31:0]      o_x,
  output logic                  o_singular,
  output logic                  o_overflow
);
  typedef enum logic [3:0] {
    IDLE, DET_A, DET_0, DET_1, DET_2, DIV_0, DIV_1, DIV_2, DONE
  } state_t;

  state_t                state_q, state_d;
  logic [0:2][0:2][31:0] a_q, a_d;
  logic [0:2][31:0]      b_q, b_d;
  logic [0:2][31:0]      det_q, det_d;
  logic [0:2][31:0]      x_q, x_d;
  logic [31:0]           det_a_q, det_a_d;
  logic                  ready_q, ready_d;
  logic                  valid_q, valid_d;
  logic                  sing_q, sing_d;
  logic                  ovf_q, ovf_d;

  logic [0:2][0:2][31:0] det_m;
  logic [31:0]           det_out, det_abs;
  logic [31:0]           div_num, div_den, div_quot;
  logic                  det_ovf, div_ovf, div_unf;
  logic                  is_det_k, is_div_k, singular_hit;
  logic [1:0]            k_sel;

  always_comb begin
    k_sel    = 2'd0;
    is_det_k = 1'b0;
    is_div_k = 1'b0;
    case (state_q)
      DET_0: begin k_sel = 2'd0; is_det_k = 1'b1; end
      DET_1: begin k_sel = 2'd1; is_det_k = 1'b1; end
      DET_2: begin k_sel = 2'd2; is_det_k = 1'b1; end
      DIV_0: begin k_sel = 2'd0; is_div_k = 1'b1; end
      DIV_1: begin k_sel = 2'd1; is_div_k = 1'b1; end
      DIV_2: begin k_sel = 2'd2; is_div_k = 1'b1; end
      default: ;
    endcase
  end

  // Shared-unit operands stay zero outside their states so idle flags are harmless.
  always_comb begin
    det_m   = '0;
    div_num = '0;
    div_den = '0;
    if (state_q == DET_A) begin
      det_m = a_q;
    end
    if (is_det_k) begin
      det_m = a_q;
      for (int r = 0; r < 3; r++) begin
        det_m[r][k_sel] = b_q[r];
      end
    end
    if (is_div_k) begin
      div_num = det_q[k_sel];
      div_den = det_a_q;
    end
  end

  fip_32_3b3_det u_det (
    .i_m   (det_m),
    .o_det (det_out),
    .o_ovf (det_ovf)
  );

  fip_32_div u_div (
    .i_dividend (div_num),
    .i_divisor  (div_den),
    .o_quot     (div_quot),
    .o_ovf      (div_ovf),
    .o_unf      (div_unf)
  );

  // Most-negative value saturates so it can never look singular.
  assign det_abs = (det_out == 32'h8000_0000) ? 32'h7FFF_FFFF :
                   (det_out[31] ? (~det_out + 32'd1) : det_out);
  assign singular_hit = (det_abs <= SINGULAR_EPS) || (OVF_ABORT && det_ovf);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    det_d   = det_q;
    det_a_d = det_a_q;
    x_d     = x_q;
    ready_d = ready_q;
    valid_d = valid_q;
    sing_d  = sing_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (i_valid && ready_q) begin
          a_d     = i_matrix;
          b_d     = i_rhs;
          x_d     = '0;
          sing_d  = 1'b0;
          ovf_d   = 1'b0;
          ready_d = 1'b0;
          state_d = DET_A;
        end
      end
      DET_A: begin
        det_a_d = det_out;
        ovf_d   = ovf_q | det_ovf;
        if (singular_hit) begin
          sing_d  = 1'b1;
          x_d     = '0;
          valid_d = 1'b1;
          state_d = DONE;
        end else begin
          state_d = DET_0;
        end
      end
      DET_0, DET_1, DET_2: begin
        det_d[k_sel] = det_out;
        ovf_d        = ovf_q | det_ovf;
        state_d      = state_t'(state_q + 4'd1);
      end
      DIV_0, DIV_1, DIV_2: begin
        x_d[k_sel] = div_quot;
        ovf_d      = ovf_q | div_ovf | div_unf;
        if (state_q == DIV_2) begin
          valid_d = 1'b1;
          state_d = DONE;
        end else begin
          state_d = state_t'(state_q + 4'd1);
        end
      end
      DONE: begin
        if (i_ready) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      det_q   <= '0;
      det_a_q <= '0;
      x_q     <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      sing_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      det_q   <= det_d;
      det_a_q <= det_a_d;
      x_q     <= x_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      sing_q  <= sing_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_ready    = ready_q;
  assign o_valid    = valid_q;
  assign o_x        = x_q;
  assign o_singular = sing_q;
  assign o_overflow = ovf_q;
endmodule

// File: tb/tb_fip_32_cramer_solver.sv
// Scoreboard bench for fip_32_cramer_solver: two instances (default parameters and
// OVF_ABORT=1 with a non-zero epsilon), exact-arithmetic reference model.

module tb_fip_32_cramer_solver;
  typedef logic [0:2][0:2][31:0] mat_t;
  typedef logic [0:2][31:0]      vec_t;
  typedef struct {
    vec_t   x;
    logic   sing;
    logic   ovf;
    int     lat;
    int     stall;
    longint acc;
  } exp_t;

  localparam logic [31:0] ONE  = 32'h0001_0000;
  localparam logic [31:0] EPS0 = 32'd0;
  localparam logic [31:0] EPS1 = 32'd16;
  // Even permutations first, odd ones last.
  localparam int PERM [6][3] = '{'{0,1,2}, '{1,2,0}, '{2,0,1}, '{0,2,1}, '{1,0,2}, '{2,1,0}};

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid  [2];
  logic out_ready [2];
  mat_t in_mat    [2];
  vec_t in_rhs    [2];
  logic out_valid [2];
  logic in_ready  [2];
  vec_t out_x     [2];
  logic out_sing  [2];
  logic out_ovf   [2];

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  exp_t   q0[$];
  exp_t   q1[$];
  bit     have     [2];
  bit     exp_idle [2];
  int     stall_left [2];
  vec_t   held_x   [2];
  logic   held_s   [2];
  logic   held_o   [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fip_32_cramer_solver #(.SINGULAR_EPS(EPS0), .OVF_ABORT(1'b0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_valid[0]), .o_ready(out_ready[0]),
    .i_matrix(in_mat[0]), .i_rhs(in_rhs[0]), .o_valid(out_valid[0]), .i_ready(in_ready[0]),
    .o_x(out_x[0]), .o_singular(out_sing[0]), .o_overflow(out_ovf[0])
  );

  fip_32_cramer_solver #(.SINGULAR_EPS(EPS1), .OVF_ABORT(1'b1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_valid[1]), .o_ready(out_ready[1]),
    .i_matrix(in_mat[1]), .i_rhs(in_rhs[1]), .o_valid(out_valid[1]), .i_ready(in_ready[1]),
    .o_x(out_x[1]), .o_singular(out_sing[1]), .o_overflow(out_ovf[1])
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endfunction

  function automatic void chk1(input string name, input logic act, input logic req);
    chk(name, 32'(act), 32'(req));
  endfunction

  // Exact determinant (Leibniz sum in wide integers), rescaled to Q16.16 by floor.
  function automatic void det_ref(input mat_t m, output logic [31:0] d, output logic ovf);
    logic signed [127:0] s, t, q;
    s = '0;
    for (int p = 0; p < 6; p++) begin
      t = 128'($signed(m[0][PERM[p][0]])) * 128'($signed(m[1][PERM[p][1]]))
        * 128'($signed(m[2][PERM[p][2]]));
      if (p < 3) s = s + t;
      else       s = s - t;
    end
    q   = s >>> 32;
    d   = q[31:0];
    ovf = (q > 128'sd2147483647) || (q < -128'sd2147483648);
  endfunction

  function automatic exp_t model(input mat_t a, input vec_t b, input logic [31:0] eps,
                                 input bit abort_on_ovf);
    exp_t        e;
    logic [31:0] da, dk;
    logic        o;
    longint      mag, n, dv, qv;
    mat_t        m;
    e.x = '0; e.sing = 1'b0; e.ovf = 1'b0; e.lat = 8; e.stall = 0; e.acc = 0;
    det_ref(a, da, o);
    e.ovf = o;
    mag = longint'($signed(da));
    if (mag < 0) mag = -mag;
    if (mag > 64'sd2147483647) mag = 64'sd2147483647;
    if (mag <= longint'(eps) || (abort_on_ovf && o)) begin
      e.sing = 1'b1;
      e.lat  = 2;
      return e;
    end
    for (int k = 0; k < 3; k++) begin
      m = a;
      for (int r = 0; r < 3; r++) m[r][k] = b[r];
      det_ref(m, dk, o);
      e.ovf = e.ovf | o;
    end
    for (int k = 0; k < 3; k++) begin
      m = a;
      for (int r = 0; r < 3; r++) m[r][k] = b[r];
      det_ref(m, dk, o);
      n  = longint'($signed(dk)) * 64'sd65536;
      dv = longint'($signed(da));
      qv = n / dv;
      if (qv > 64'sd2147483647 || qv < -64'sd2147483648) e.ovf = 1'b1;
      if (n != 0 && qv == 0) e.ovf = 1'b1;
      e.x[k] = qv[31:0];
    end
    return e;
  endfunction

  function automatic exp_t mk(input vec_t x, input logic s, input logic o, input int lat,
                              input int stall);
    exp_t e;
    e.x = x; e.sing = s; e.ovf = o; e.lat = lat; e.stall = stall; e.acc = 0;
    return e;
  endfunction

  function automatic logic [31:0] rnd_val(input bit full);
    logic [31:0] v;
    if (full) v = $urandom;
    else      v = 32'($urandom_range(0, 32'h80000)) - 32'h40000;
    return v;
  endfunction

  function automatic mat_t rnd_mat(input int mode);
    mat_t m;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        m[r][c] = rnd_val(mode == 1);
    if (mode == 2) m[2] = m[0];
    return m;
  endfunction

  function automatic vec_t rnd_vec(input bit full);
    vec_t v;
    for (int r = 0; r < 3; r++) v[r] = rnd_val(full);
    return v;
  endfunction

  function automatic mat_t diag3(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    mat_t m;
    m = '0;
    m[0][0] = d0; m[1][1] = d1; m[2][2] = d2;
    return m;
  endfunction

  function automatic vec_t vec3(input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v2);
    vec_t v;
    v[0] = v0; v[1] = v1; v[2] = v2;
    return v;
  endfunction

  function automatic void mon_step(input int d);
    exp_t e;
    if (!rst_n) begin
      have[d] = 0; exp_idle[d] = 0; in_ready[d] = 1'b0;
      return;
    end
    if (exp_idle[d]) begin
      chk1($sformatf("d%0d_valid_drop", d), out_valid[d], 1'b0);
      chk1($sformatf("d%0d_ready_back", d), out_ready[d], 1'b1);
      exp_idle[d] = 0;
    end
    if (!out_valid[d]) begin
      in_ready[d] = 1'b0;
      return;
    end
    chk1($sformatf("d%0d_ready_low_in_done", d), out_ready[d], 1'b0);
    if (!have[d]) begin
      chk1($sformatf("d%0d_result_expected", d), (d == 0) ? (q0.size() != 0) : (q1.size() != 0), 1'b1);
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        in_ready[d] = 1'b1;
        return;
      end
      if (d == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      for (int k = 0; k < 3; k++)
        chk($sformatf("d%0d_x%0d", d, k), out_x[d][k], e.x[k]);
      chk1($sformatf("d%0d_singular", d), out_sing[d], e.sing);
      chk1($sformatf("d%0d_overflow", d), out_ovf[d], e.ovf);
      chk($sformatf("d%0d_latency", d), 32'(cyc - e.acc), 32'(e.lat));
      held_x[d] = out_x[d]; held_s[d] = out_sing[d]; held_o[d] = out_ovf[d];
      stall_left[d] = e.stall;
      have[d] = 1;
    end else begin
      for (int k = 0; k < 3; k++)
        chk($sformatf("d%0d_hold_x%0d", d, k), out_x[d][k], held_x[d][k]);
      chk1($sformatf("d%0d_hold_sing", d), out_sing[d], held_s[d]);
      chk1($sformatf("d%0d_hold_ovf", d), out_ovf[d], held_o[d]);
    end
    if (stall_left[d] == 0) begin
      in_ready[d] = 1'b1;
      have[d]     = 0;
      exp_idle[d] = 1;
    end else begin
      in_ready[d] = 1'b0;
      stall_left[d]--;
    end
  endfunction

  initial begin
    for (int d = 0; d < 2; d++) begin
      have[d] = 0; exp_idle[d] = 0; stall_left[d] = 0; in_ready[d] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) mon_step(d);
    end
  end

  task automatic send_e(input int d, input mat_t a, input vec_t b, input exp_t e);
    int n;
    n = 0;
    @(negedge clk);
    in_mat[d] = a; in_rhs[d] = b; in_valid[d] = 1'b1;
    while (!out_ready[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk1($sformatf("d%0d_accept_in_time", d), out_ready[d], 1'b1);
    if (out_ready[d]) begin
      e.acc = cyc;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    @(negedge clk);
    in_valid[d] = 1'b0;
    in_mat[d]   = rnd_mat(1);
    in_rhs[d]   = rnd_vec(1);
  endtask

  task automatic send(input int d, input mat_t a, input vec_t b, input int stall);
    exp_t e;
    e = model(a, b, (d == 0) ? EPS0 : EPS1, d == 1);
    e.stall = stall;
    send_e(d, a, b, e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || have[0] || have[1] || exp_idle[0] || exp_idle[1])
           && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk1("drain_in_time", n < 1000, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_zero(input int d, input string tag);
    chk1($sformatf("d%0d_%s_valid", d, tag), out_valid[d], 1'b0);
    chk1($sformatf("d%0d_%s_ready", d, tag), out_ready[d], 1'b0);
    chk1($sformatf("d%0d_%s_sing", d, tag), out_sing[d], 1'b0);
    chk1($sformatf("d%0d_%s_ovf", d, tag), out_ovf[d], 1'b0);
    for (int k = 0; k < 3; k++)
      chk($sformatf("d%0d_%s_x%0d", d, tag, k), out_x[d][k], 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    mat_t ident, seq9, big, m;
    vec_t ones, b123;
    int   mode;

    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; in_mat[d] = '0; in_rhs[d] = '0;
    end
    ident = diag3(ONE, ONE, ONE);
    big   = diag3(32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000);
    ones  = vec3(ONE, ONE, ONE);
    b123  = vec3(ONE, 32'h0002_0000, 32'h0003_0000);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        seq9[r][c] = 32'(3 * r + c + 1) << 16;

    rst_n = 1'b0;
    #1;
    check_zero(0, "rst");
    check_zero(1, "rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk1("d0_ready_after_rst", out_ready[0], 1'b1);
    chk1("d1_ready_after_rst", out_ready[1], 1'b1);

    send_e(0, ident, b123, mk(vec3(32'h10000, 32'h20000, 32'h30000), 1'b0, 1'b0, 8, 0));
    send_e(0, diag3(32'h20000, 32'h40000, 32'h8000), ones,
           mk(vec3(32'h8000, 32'h4000, 32'h20000), 1'b0, 1'b0, 8, 0));
    send_e(0, seq9, ones, mk('0, 1'b1, 1'b0, 2, 0));
    send(0, big, ones, 5);
    send_e(0, ident, b123, mk(vec3(32'h10000, 32'h20000, 32'h30000), 1'b0, 1'b0, 8, 1));

    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 3);
      m = rnd_mat(mode);
      send(0, m, rnd_vec(mode == 1), $urandom_range(0, 3));
    end
    drain();

    send(0, ident, b123, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    void'(q0.pop_back());
    #1;
    check_zero(0, "midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk1("d0_ready_after_midrst", out_ready[0], 1'b1);
    repeat (20) @(negedge clk);
    send_e(0, ident, b123, mk(vec3(32'h10000, 32'h20000, 32'h30000), 1'b0, 1'b0, 8, 0));
    drain();

    send_e(1, big, ones, mk('0, 1'b1, 1'b1, 2, 0));
    send_e(1, diag3(32'h10, ONE, ONE), ones, mk('0, 1'b1, 1'b0, 2, 2));
    send(1, diag3(32'h11, ONE, ONE), ones, 0);
    send_e(1, ident, b123, mk(vec3(32'h10000, 32'h20000, 32'h30000), 1'b0, 1'b0, 8, 0));
    for (int i = 0; i < 12; i++) begin
      mode = $urandom_range(0, 3);
      m = rnd_mat(mode);
      send(1, m, rnd_vec(mode == 1), $urandom_range(0, 2));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
